// File: rtl/traffic_sensor_model.sv
// rtl/traffic_sensor_model.sv - vehicle queues and sensors driven by the traffic light outputs
//
// Purpose: holds one vehicle queue per lane (E-W straight, E-W left, N-S), accepts
// arrival pulses, releases vehicles on "go" at one vehicle per DEP_INT go cycles,
// drives queue-nonempty sensors back to the light controller and flags illegal
// light combinations.
//
// Configuration macro: YELLOW_GO_EN (defined: yellow counts as go; default: green only).
//
// Ports:
//   clk                       rising-edge clock
//   reset                     synchronous, active-low
//   str_light/left_light/ns_light  2-bit light colors (red=00, yellow=01, green=10)
//   arr_s/arr_l/arr_n         one-cycle arrival pulses per lane
//   s_s/l_s/n_s               lane sensors (queue nonempty)
//   cnt_s/cnt_l/cnt_n         per-lane queue occupancy
//   dep_total                 total departures, wraps
//   ovf                       sticky per-lane overflow {n,l,s}
//   err_conflict              sticky illegal light combination
module traffic_sensor_model #(
    parameter int QW      = 4,
    parameter int DEP_INT = 3,
    parameter int TW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    str_light,
    input  logic [1:0]    left_light,
    input  logic [1:0]    ns_light,
    input  logic          arr_s,
    input  logic          arr_l,
    input  logic          arr_n,
    output logic          s_s,
    output logic          l_s,
    output logic          n_s,
    output logic [QW-1:0] cnt_s,
    output logic [QW-1:0] cnt_l,
    output logic [QW-1:0] cnt_n,
    output logic [TW-1:0] dep_total,
    output logic [2:0]    ovf,
    output logic          err_conflict
);

    localparam int TMW = (DEP_INT > 1) ? $clog2(DEP_INT) : 1;
    localparam logic [TMW-1:0] T_LAST = TMW'(DEP_INT - 1);
    localparam logic [QW-1:0]  Q_FULL = '1;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] GREEN   = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Lane index: 0 = E-W straight, 1 = E-W left, 2 = N-S
    logic [1:0]     light [3];
    logic [2:0]     arr;
    logic [QW-1:0]  cnt_q [3];
    logic [TMW-1:0] tmr_q [3];
    logic [2:0]     go;
    logic [2:0]     dep;
    logic [1:0]     dep_sum;
    logic [2:0]     non_red;
    logic           conflict;

    assign light[0] = str_light;
    assign light[1] = left_light;
    assign light[2] = ns_light;
    assign arr      = {arr_n, arr_l, arr_s};

    always_comb begin
        go  = '0;
        dep = '0;
        for (int i = 0; i < 3; i++) begin
`ifdef YELLOW_GO_EN
            go[i] = (light[i] == GREEN) || (light[i] == YELLOW);
`else
            go[i] = (light[i] == GREEN);
`endif
            // A departure needs a vehicle already queued; a same-cycle arrival
            // only becomes eligible from the next go cycle.
            dep[i] = go[i] && (tmr_q[i] == T_LAST) && (cnt_q[i] != '0);
        end
    end

    always_comb begin
        dep_sum  = {1'b0, dep[0]} + {1'b0, dep[1]} + {1'b0, dep[2]};
        non_red  = {ns_light != RED, left_light != RED, str_light != RED};
        conflict = (non_red[0] && non_red[1]) || (non_red[0] && non_red[2]) ||
                   (non_red[1] && non_red[2]) ||
                   (str_light == ILLEGAL) || (left_light == ILLEGAL) ||
                   (ns_light == ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                tmr_q[i] <= '0;
            end
            dep_total    <= '0;
            ovf          <= '0;
            err_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                // Pacing: no partial credit survives a loss of go. With an empty
                // queue at terminal count the timer parks there, so the next
                // queued vehicle leaves on the following go cycle.
                if (!go[i]) begin
                    tmr_q[i] <= '0;
                end else if (tmr_q[i] == T_LAST) begin
                    tmr_q[i] <= dep[i] ? '0 : T_LAST;
                end else begin
                    tmr_q[i] <= tmr_q[i] + 1'b1;
                end

                if (arr[i] && !dep[i]) begin
                    if (cnt_q[i] == Q_FULL) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else if (dep[i] && !arr[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            dep_total <= dep_total + TW'(dep_sum);
            if (conflict) begin
                err_conflict <= 1'b1;
            end
        end
    end

    assign cnt_s = cnt_q[0];
    assign cnt_l = cnt_q[1];
    assign cnt_n = cnt_q[2];
    assign s_s   = (cnt_q[0] != '0);
    assign l_s   = (cnt_q[1] != '0);
    assign n_s   = (cnt_q[2] != '0);

endmodule
